uart_tx_mmio: RTL and testbench
===============================

# uart_tx_mmio

Memory-mapped UART transmitter that consumes the CPU's writeback-stage store stream (`MemWriteW`, `Mem_WrAddr`, `Mem_WrData`, `funct3`) at the console address `0x1000_0000`. Accepted bytes are buffered in a small FIFO and serialized as 8N1 frames on `tx`. It also exposes a read-back status word on the MMIO read path. It is the synthesizable replacement for the console-print behaviour of the simulation memory model.

## Interface
- `BASE_ADDR`, `32'h1000_0000`: byte address of the TXDATA register. STATUS is at `BASE_ADDR+4`.
- `CLKS_PER_BIT`, `16`: clock cycles per UART bit. Must be ≥2.
- `FIFO_DEPTH`, `8`: TX FIFO entries. Must be a power of two, ≥2.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `we` in 1: store strobe (driven from `MemWriteW`).
- `addr` in 32: byte address of the access (`Mem_WrAddr`).
- `wdata` in 32: store data (`Mem_WrData`). Only `[7:0]` is used.
- `funct3` in 3: access size. Stores with size `000` (SB) and `010` (SW) are accepted; any other size is ignored.
- `rdata` out 32: registered read data for the current `addr`.
- `tx` out 1: serial output. Idle level is high.
- `busy` out 1: high while a frame is in flight or the FIFO is non-empty.

## Operation
- **Write decode**
  - TXDATA write: `we` && `addr==BASE_ADDR` && size accepted. Pushes `wdata[7:0]` into the FIFO.
  - STATUS write: `we` && `addr==BASE_ADDR+4`. Clears `overflow`.
- **Read decode**
  - `rdata` is registered every cycle.
  - `addr==BASE_ADDR+4` gives STATUS: `{24'b0, count[3:0], overflow, tx_busy, empty, full}`, with bit0=`full`.
  - Any other address gives `32'b0`.
- **FIFO**
  - Circular buffer with read/write pointers and a count of width `$clog2(FIFO_DEPTH)+1`. Pointers wrap modulo `FIFO_DEPTH`.
  - Push when full with no pop in the same cycle: the byte is dropped and `overflow` is set. `overflow` is sticky.
  - Push and pop in the same cycle: both take effect and count is unchanged. This holds even when the FIFO is full.
- **FSM states:** IDLE, START, DATA, STOP.
  - IDLE: `tx=1`. If the FIFO is non-empty, pop the head into `shreg`, clear `baud_cnt` and `bit_idx`, and go to START.
  - START: `tx=0` for `CLKS_PER_BIT` cycles, then go to DATA.
  - DATA: `tx=shreg[0]`. At each bit end, shift right and increment `bit_idx`. After 8 bits (LSB first), go to STOP.
  - STOP: `tx=1` for `CLKS_PER_BIT` cycles, then go to IDLE.
- `baud_cnt` runs from 0 to `CLKS_PER_BIT-1`. A bit ends when `baud_cnt==CLKS_PER_BIT-1`.
- `tx_busy` = state≠IDLE. `busy` = `tx_busy` | ~empty.

## Timing
- **Reset values:** state=IDLE, `tx=1`, `busy=0`, `rdata=0`, FIFO empty, `overflow=0`, all counters 0.
- **Write to line:** a write sampled at edge N lands in the FIFO at N. IDLE pops at N+1, and `tx` falls right after N+1.
- **Frame length:** exactly `10*CLKS_PER_BIT` cycles of `tx` activity.
- **Back-to-back frames:** each byte costs `10*CLKS_PER_BIT+1` cycles, because of one IDLE cycle at `tx=1` between frames.
- **Read latency:** `rdata` is valid 1 cycle after `addr` is presented.
- **STATUS write and overflow in the same cycle:** the set wins, so `overflow` stays 1.
- **Reset mid-frame:** `tx` returns to 1 immediately (asynchronously) and FIFO contents are discarded.

## Configuration
- `UART_TX_SIM_PRINT_EN` defined: every accepted TXDATA push also executes `$write("%c", wdata[7:0])`. Dropped pushes do not print. The hardware behaviour is unchanged.
- `UART_TX_SIM_PRINT_EN` undefined: no simulator output. The block is fully synthesizable.

## Test plan
All scenarios use `CLKS_PER_BIT=4` and `FIFO_DEPTH=4`.
- **Single byte:** SB `0x41` to `0x1000_0000`. Expect `tx` = 0 for 4 cycles, then bits 1,0,0,0,0,0,1,0 (4 cycles each), then 1 for 4 cycles. `busy` falls 41 cycles after the write edge.
- **Back-to-back:** SW `0xDEAD_BE55`, then SB `0xAA`. Expect frames `0x55` and `0xAA` with exactly one idle-high cycle between them, and STATUS=`0x0000_0002` afterwards.
- **Overflow:** 6 writes in 6 consecutive cycles.
  - The first byte is popped at cycle 2, so the FIFO fills after the 5th write and the 6th write is dropped.
  - STATUS read returns `full=1`, `overflow=1`, count=4.
  - A STATUS write then clears `overflow`.
  - Only 5 frames appear on `tx`.
- **Ignored accesses:**
  - SH to `0x1000_0000`: no frame.
  - Write to `0x1000_0008`: no frame and no state change.
  - Read of `0x1000_0000`: returns 0.
- **Reset mid-frame:** assert `reset` during DATA bit 3. Expect `tx=1` within the same cycle, STATUS=`0x0000_0002` after release, and no residual frame.

Source files
------------

// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio
// Memory-mapped console UART transmitter. Byte stores to BASE_ADDR (TXDATA)
// are queued in a small FIFO and sent as 8N1 frames on tx, LSB first.
// BASE_ADDR+4 (STATUS) reads back {24'b0, count[3:0], overflow, tx_busy,
// empty, full}; any store to STATUS clears the sticky overflow flag.
//
// Build option: define UART_TX_SIM_PRINT_EN to echo every accepted TXDATA
// byte to the simulator transcript with $write. Leave it undefined for
// synthesis; the hardware behaviour is the same either way.
//
// Store handshake: the store port has no ready. A store is presented for a
// single cycle with we=1 and is either taken on that clock edge or lost.
// A TXDATA store that finds the FIFO full, with no pop in the same cycle,
// is dropped and raises overflow. There is no back-pressure to the CPU.
//
// dbg_state_o exposes the transmitter FSM state for debug.

module uart_tx_mmio #(
  parameter logic [31:0] BASE_ADDR    = 32'h1000_0000,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [2:0]  funct3,
  output logic [31:0] rdata,
  output logic        tx,
  output logic        busy,
  output logic [1:0]  dbg_state_o
);

  // Widths derived from the configuration.
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [31:0]   STATUS_ADDR = BASE_ADDR + 32'd4;
  localparam logic [CW-1:0] DEPTH_C     = CW'(FIFO_DEPTH);
  localparam logic [BW-1:0] BAUD_LAST   = BW'(CLKS_PER_BIT - 1);

  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SW = 3'b010;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_e;

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  state_e          state_q,    state_d;
  logic [BW-1:0]   baud_q,     baud_d;
  logic [2:0]      bit_idx_q,  bit_idx_d;
  logic [7:0]      shreg_q,    shreg_d;

  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_q,   wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q,   rd_ptr_d;
  logic [CW-1:0]   count_q,    count_d;
  logic            overflow_q, overflow_d;
  logic [31:0]     rdata_q,    rdata_d;

  // ---------------------------------------------------------------------
  // Decode
  // ---------------------------------------------------------------------
  logic        size_ok;
  logic        push_req;
  logic        status_wr;
  logic        empty;
  logic        full;
  logic        pop;
  logic        push_ok;
  logic        drop;
  logic        tx_busy;
  logic        bit_end;
  logic [3:0]  count4;
  logic [31:0] status_word;
  logic        unused_wdata_hi;

  // Only the low byte of the store data is transmitted.
  assign unused_wdata_hi = ^wdata[31:8];

  // Classify the current store and the FIFO condition.
  always_comb begin
    size_ok   = (funct3 == F3_SB) || (funct3 == F3_SW);
    push_req  = we && (addr == BASE_ADDR) && size_ok;
    status_wr = we && (addr == STATUS_ADDR);
    empty     = (count_q == '0);
    full      = (count_q == DEPTH_C);
    pop       = (state_q == S_IDLE) && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    push_ok   = push_req && (!full || pop);
    drop      = push_req && full && !pop;
    tx_busy   = (state_q != S_IDLE);
    bit_end   = (baud_q == BAUD_LAST);
  end

  // ---------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------

  // Next pointers, occupancy and sticky overflow.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)     rd_ptr_d = rd_ptr_q + PW'(1);
    unique case ({push_ok, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    // A dropped byte outranks a clear arriving in the same cycle.
    if (drop) begin
      overflow_d = 1'b1;
    end else if (status_wr) begin
      overflow_d = 1'b0;
    end
  end

  // FIFO control registers; reset discards any queued bytes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // FIFO storage; contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata[7:0];
  end

  // ---------------------------------------------------------------------
  // Transmitter FSM
  // ---------------------------------------------------------------------

  // Next-state logic: one start bit, eight data bits LSB first, one stop bit.
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    shreg_d   = shreg_q;
    unique case (state_q)
      S_IDLE: begin
        if (!empty) begin
          shreg_d   = mem_q[rd_ptr_q];
          baud_d    = '0;
          bit_idx_d = '0;
          state_d   = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          baud_d  = '0;
          state_d = S_DATA;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      S_DATA: begin
        if (bit_end) begin
          baud_d    = '0;
          shreg_d   = {1'b0, shreg_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = S_STOP;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      S_STOP: begin
        if (bit_end) begin
          baud_d  = '0;
          state_d = S_IDLE;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shreg_q   <= '0;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      shreg_q   <= shreg_d;
    end
  end

  // Line level decoded from registered state, so reset forces it high at once.
  always_comb begin
    tx = 1'b1;
    unique case (state_q)
      S_IDLE:  tx = 1'b1;
      S_START: tx = 1'b0;
      S_DATA:  tx = shreg_q[0];
      S_STOP:  tx = 1'b1;
      default: tx = 1'b1;
    endcase
  end

  // ---------------------------------------------------------------------
  // Read path and status
  // ---------------------------------------------------------------------

  // Assemble STATUS and select the read data for the current address.
  always_comb begin
    count4      = 4'(count_q);
    status_word = {24'b0, count4, overflow_q, tx_busy, empty, full};
    rdata_d     = (addr == STATUS_ADDR) ? status_word : 32'b0;
  end

  // Read data is registered every cycle: valid one cycle after addr.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata_q <= 32'b0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata       = rdata_q;
  assign busy        = tx_busy | ~empty;
  assign dbg_state_o = state_q;

`ifdef UART_TX_SIM_PRINT_EN
  // Echo each accepted console byte to the simulator transcript.
  always_ff @(posedge clk) begin
    if (!reset && push_ok) $write("%c", wdata[7:0]);
  end
`endif

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Bench for uart_tx_mmio with CLKS_PER_BIT=4, FIFO_DEPTH=4.
// A behavioural model tracks the queued bytes, the sticky overflow flag and
// the time window each frame occupies on the line; the expected tx level is
// computed from the frame start time and the byte. A line receiver decodes
// frames independently and checks them against an expected-byte queue.

`timescale 1ns/1ps

module tb_uart_tx_mmio;

  localparam int          CPB   = 4;
  localparam int          DEPTH = 4;
  localparam int          FRAME = 10 * CPB;
  localparam logic [31:0] BASE  = 32'h1000_0000;
  localparam logic [31:0] STAT  = 32'h1000_0004;

  // ---------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------
  logic        clk = 1'b0;
  logic        reset;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [2:0]  funct3;
  logic [31:0] rdata;
  logic        tx;
  logic        busy;
  logic [1:0]  dbg_state;

  always #5 clk = ~clk;

  uart_tx_mmio #(
    .BASE_ADDR   (BASE),
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .we         (we),
    .addr       (addr),
    .wdata      (wdata),
    .funct3     (funct3),
    .rdata      (rdata),
    .tx         (tx),
    .busy       (busy),
    .dbg_state_o(dbg_state)
  );

  // ---------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------
  logic [7:0]  m_fifo[$];
  logic [7:0]  exp_q[$];
  bit          m_ovf = 1'b0;
  int          cyc = 0;
  int          frame_end = 0;
  int          frame_start = 0;
  logic [7:0]  frame_byte = 8'h00;
  bit          have_frame = 1'b0;
  logic [31:0] m_rdata = 32'h0;
  bit          m_pop;
  bit          m_acc;
  bit          m_full_pre;
  bit          m_busy_pre;
  logic [31:0] m_status;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_fifo.delete();
      exp_q.delete();
      m_ovf      = 1'b0;
      frame_end  = cyc;
      have_frame = 1'b0;
      m_rdata    = 32'h0;
    end else begin
      cyc++;
      m_busy_pre = (cyc - 1) < frame_end;
      m_full_pre = (m_fifo.size() == DEPTH);
      m_status   = {24'b0, 4'(m_fifo.size()), m_ovf, m_busy_pre,
                    (m_fifo.size() == 0), m_full_pre};
      m_rdata    = (addr == STAT) ? m_status : 32'h0;
      m_pop      = !m_busy_pre && (m_fifo.size() > 0);
      m_acc      = we && (addr == BASE) && (funct3 == 3'd0 || funct3 == 3'd2);
      if (m_pop) begin
        frame_byte  = m_fifo.pop_front();
        frame_start = cyc;
        frame_end   = cyc + FRAME;
        have_frame  = 1'b1;
        exp_q.push_back(frame_byte);
      end
      if (we && addr == STAT) m_ovf = 1'b0;
      if (m_acc) begin
        if (!m_full_pre || m_pop) m_fifo.push_back(wdata[7:0]);
        else                      m_ovf = 1'b1;
      end
    end
  end

  function automatic logic exp_tx();
    int d;
    if (!have_frame || cyc >= frame_start + FRAME) return 1'b1;
    d = (cyc - frame_start) / CPB;
    if (d == 0) return 1'b0;
    if (d <= 8) return frame_byte[d-1];
    return 1'b1;
  endfunction

  // Cycle-by-cycle comparison of every output against the model.
  always @(negedge clk) begin
    check("tx_line", {31'b0, tx}, {31'b0, exp_tx()});
    check("busy", {31'b0, busy},
          {31'b0, ((cyc < frame_end) || (m_fifo.size() > 0))});
    check("rdata", rdata, m_rdata);
  end

  // ---------------------------------------------------------------------
  // Line receiver / scoreboard
  // ---------------------------------------------------------------------
  int         rx_idx = -1;
  logic [7:0] rx_byte = 8'h00;
  int         n_frames = 0;
  int         rx_starts[$];

  always @(negedge clk or posedge reset) begin
    if (reset) begin
      rx_idx = -1;
    end else if (rx_idx < 0) begin
      if (tx === 1'b0) begin
        rx_idx = 0;
        rx_starts.push_back(cyc);
      end
    end else begin
      rx_idx++;
      for (int i = 0; i < 8; i++) begin
        if (rx_idx == CPB * (i + 1) + CPB / 2) rx_byte[i] = tx;
      end
      if (rx_idx == 9 * CPB + CPB / 2) begin
        check("stop_bit", {31'b0, tx}, 32'h1);
        check("rx_expected", {31'b0, (exp_q.size() > 0)}, 32'h1);
        if (exp_q.size() > 0) check("rx_byte", {24'b0, rx_byte}, {24'b0, exp_q.pop_front()});
        n_frames++;
        rx_idx = -1;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Driver tasks (called at a negedge, return at a later negedge)
  // ---------------------------------------------------------------------
  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f);
    we = 1'b1; addr = a; wdata = d; funct3 = f;
    @(negedge clk);
    we = 1'b0; addr = 32'h0; wdata = 32'h0; funct3 = 3'd0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    addr = a;
    @(negedge clk);
    d = rdata;
    addr = 32'h0;
  endtask

  task automatic wait_idle(input int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      if (busy === 1'b0 && rx_idx < 0) break;
      @(negedge clk);
    end
    check("drain_done", {31'b0, busy}, 32'h0);
  endtask

  // ---------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------
  logic [31:0] r;
  int          f0;

  initial begin
    reset = 1'b1; we = 1'b0; addr = 32'h0; wdata = 32'h0; funct3 = 3'd0;
    repeat (3) @(negedge clk);
    check("reset_tx", {31'b0, tx}, 32'h1);
    check("reset_busy", {31'b0, busy}, 32'h0);
    check("reset_rdata", rdata, 32'h0);
    reset = 1'b0;
    bus_read(STAT, r);
    check("status_after_reset", r, 32'h0000_0002);

    // Single byte: busy falls 41 cycles after the write edge.
    f0 = n_frames;
    bus_write(BASE, 32'h0000_0041, 3'b000);
    repeat (40) @(negedge clk);
    check("busy_at_40", {31'b0, busy}, 32'h1);
    @(negedge clk);
    check("busy_fall_41", {31'b0, busy}, 32'h0);
    wait_idle(100);
    check("single_frames", 32'(n_frames - f0), 32'd1);

    // Back-to-back: SW then SB, one idle cycle between frames.
    f0 = n_frames;
    rx_starts.delete();
    bus_write(BASE, 32'hDEAD_BE55, 3'b010);
    bus_write(BASE, 32'h0000_00AA, 3'b000);
    wait_idle(200);
    check("b2b_frames", 32'(n_frames - f0), 32'd2);
    if (rx_starts.size() >= 2)
      check("b2b_spacing", 32'(rx_starts[1] - rx_starts[0]), 32'(FRAME + 1));
    else
      check("b2b_starts", 32'(rx_starts.size()), 32'd2);
    bus_read(STAT, r);
    check("b2b_status", r, 32'h0000_0002);

    // Overflow: six consecutive writes, the sixth is dropped.
    f0 = n_frames;
    for (int i = 0; i < 6; i++) bus_write(BASE, $urandom, 3'b000);
    bus_read(STAT, r);
    check("ovf_status", r, 32'h0000_004D);
    bus_write(STAT, 32'h0, 3'b010);
    bus_read(STAT, r);
    check("ovf_cleared", r, 32'h0000_0045);
    wait_idle(400);
    check("ovf_frames", 32'(n_frames - f0), 32'd5);

    // Ignored accesses.
    f0 = n_frames;
    bus_write(BASE, 32'h0000_005A, 3'b001);
    bus_write(BASE + 32'd8, 32'h0000_0033, 3'b000);
    repeat (5) @(negedge clk);
    check("ign_busy", {31'b0, busy}, 32'h0);
    check("ign_tx", {31'b0, tx}, 32'h1);
    bus_read(BASE, r);
    check("read_txdata_zero", r, 32'h0);
    bus_read(STAT, r);
    check("ign_status", r, 32'h0000_0002);
    check("ign_frames", 32'(n_frames - f0), 32'd0);

    // Reset during DATA bit 3 (0xF7 has bit 3 low).
    f0 = n_frames;
    bus_write(BASE, 32'h0000_00F7, 3'b000);
    repeat (18) @(negedge clk);
    check("bit3_low", {31'b0, tx}, 32'h0);
    #2 reset = 1'b1;
    #1 check("tx_async_reset", {31'b0, tx}, 32'h1);
    check("busy_async_reset", {31'b0, busy}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    bus_read(STAT, r);
    check("status_after_midreset", r, 32'h0000_0002);
    repeat (50) @(negedge clk);
    check("no_residual_frame", 32'(n_frames - f0), 32'd0);

    // Randomized traffic over all address and size classes.
    for (int i = 0; i < 500; i++) begin
      we = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 4))
        0, 1:    addr = BASE;
        2:       addr = STAT;
        3:       addr = BASE + 32'd8;
        default: addr = $urandom;
      endcase
      case ($urandom_range(0, 3))
        0:       funct3 = 3'b000;
        1:       funct3 = 3'b010;
        default: funct3 = 3'($urandom_range(0, 7));
      endcase
      wdata = $urandom;
      @(negedge clk);
    end
    we = 1'b0; addr = 32'h0; wdata = 32'h0; funct3 = 3'd0;
    wait_idle(2000);
    repeat (3) @(negedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Bound on total run time.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, vectors %0d", n_vec);
    $fatal(1);
  end

endmodule
